mux_tree_pipe: RTL and testbench

Parametrised, pipelined N-input, W-bit reduction tree built only from 2:1 mux cells and the constants 0/1. Per transaction it either selects one of N words (SELECT) or reduces all N words bitwise (AND, OR, XOR), with every mux primitive expressed as a 2:1 mux. One register stage per tree level and a valid/ready handshake on both sides. It is the reusable datapath primitive for arbiters, muxed register read-back, and bitwise reduction units.

---
 rtl/mux_tree_pkg.sv | 12 +
 rtl/mux2_w.sv | 19 +
 rtl/mux_tree_pipe.sv | 132 +++++++++++++
 tb/tb_mux_tree_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pkg.sv
// rtl/mux_tree_pkg.sv - shared types for the pipelined mux reduction tree
// Purpose: operation encoding carried with every transaction through the tree.
package mux_tree_pkg;

    typedef enum logic [1:0] {
        OP_SEL = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } mux_op_e;

endpackage

// File: rtl/mux2_w.sv
// rtl/mux2_w.sv - W-bit array of independent per-bit 2:1 muxes
// Purpose: the only logic primitive of the reduction tree.
// Ports: d0, d1 - data inputs; sel - per-bit select; y - y[i] = sel[i] ? d1[i] : d0[i].
module mux2_w #(
    parameter int W = 8
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] sel,
    output logic [W-1:0] y
);

    always_comb begin
        for (int i = 0; i < W; i++) begin
            y[i] = sel[i] ? d1[i] : d0[i];
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N-input select / bitwise reduction tree
// Purpose: per transaction, selects one of N words or ANDs/ORs/XORs all N words,
//          one register stage per tree level, valid/ready on both sides.
// Ports: clk, rst_n (sync, active-low);
//        in_valid/in_ready/in_data[N*W]/in_sel[L]/in_op[2] - input transaction;
//        out_valid/out_ready/out_data[W] - result, latency L = $clog2(N).
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 8,
    localparam int L = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [L-1:0]   in_sel,
    input  logic [1:0]     in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data
);

    // Single global stall: the whole pipe moves together unless the
    // last stage holds a result that downstream has not taken.
    logic adv;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NI = N >> k;
        localparam int NO = NI / 2;
        localparam int SW = L - k;

        logic [NI*W-1:0] a_in;
        logic [SW-1:0]   s_in;
        mux_op_e         op_in;
        logic            v_in;
        logic [NO*W-1:0] y;
        logic [NO*W-1:0] d_q;
        logic            v_q;

        if (k == 0) begin : g_src
            assign a_in  = in_data;
            assign s_in  = in_sel;
            assign op_in = mux_op_e'(in_op);
            assign v_in  = in_valid;
        end else begin : g_src
            assign a_in  = g_lvl[k-1].d_q;
            assign s_in  = g_lvl[k-1].g_fwd.sel_q;
            assign op_in = g_lvl[k-1].g_fwd.op_q;
            assign v_in  = g_lvl[k-1].v_q;
        end

        for (genvar j = 0; j < NO; j++) begin : g_pair
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W-1:0] s;
            logic [W-1:0] m0;
            logic [W-1:0] m1;

            assign a = a_in[2*j*W +: W];
            assign b = a_in[(2*j+1)*W +: W];

            // Each op is mapped onto a mux: the left operand steers, the
            // right operand (or a constant) supplies the data legs.
            always_comb begin
                s  = {W{s_in[0]}};
                m0 = a;
                m1 = b;
                case (op_in)
                    OP_AND: begin
                        s  = a;
                        m0 = '0;
                        m1 = b;
                    end
                    OP_OR: begin
                        s  = a;
                        m0 = b;
                        m1 = '1;
                    end
                    OP_XOR: begin
                        s  = a;
                        m0 = b;
                        m1 = ~b;
                    end
                    default: ;
                endcase
            end

            mux2_w #(.W(W)) u_mux (
                .d0  (m0),
                .d1  (m1),
                .sel (s),
                .y   (y[j*W +: W])
            );
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                d_q <= '0;
                v_q <= 1'b0;
            end else if (adv) begin
                d_q <= y;
                v_q <= v_in;
            end
        end

        // The last level needs neither op nor sel downstream, so only the
        // earlier levels forward them; sel shrinks by the bit just consumed.
        if (k < L - 1) begin : g_fwd
            logic [SW-2:0] sel_q;
            mux_op_e       op_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sel_q <= '0;
                    op_q  <= OP_SEL;
                end else if (adv) begin
                    sel_q <= s_in[SW-1:1];
                    op_q  <= op_in;
                end
            end
        end
    end

    assign adv       = !g_lvl[L-1].v_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = g_lvl[L-1].v_q;
    assign out_data  = g_lvl[L-1].d_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - self-checking bench for mux_tree_pipe (N=8/W=8 and N=2/W=1)
module tb_mux_tree_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [2:0]  in_sel = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [1:0]  in_data2 = '0;
    logic [0:0]  in_sel2 = '0;
    logic [1:0]  in_op2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [0:0]  out_data2;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         acc_q[$];
    logic [7:0] got_q[$];
    int         gcyc_q[$];

    mux_tree_pipe #(.W(8), .N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    mux_tree_pipe #(.W(1), .N(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .in_sel    (in_sel2),
        .in_op     (in_op2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: result of a transaction computed directly from the word list.
    function automatic logic [7:0] model(input logic [1:0] op, input logic [2:0] sel,
                                         input logic [63:0] d);
        logic [7:0] r;
        case (op)
            2'd0: r = d[int'(sel)*8 +: 8];
            2'd1: begin r = 8'hFF; for (int i = 0; i < 8; i++) r = r & d[i*8 +: 8]; end
            2'd2: begin r = 8'h00; for (int i = 0; i < 8; i++) r = r | d[i*8 +: 8]; end
            default: begin r = 8'h00; for (int i = 0; i < 8; i++) r = r ^ d[i*8 +: 8]; end
        endcase
        return r;
    endfunction

    // Record handshakes that will complete at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_op, in_sel, in_data));
                acc_q.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                gcyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_q();
        exp_q.delete(); acc_q.delete(); got_q.delete(); gcyc_q.delete();
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] sel, input logic [63:0] d);
        logic ok;
        int   n;
        in_valid = 1'b1; in_op = op; in_sel = sel; in_data = d;
        n = 0;
        do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 50);
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", ok);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int c = 0;
        while (got_q.size() < n && c < 60) begin
            @(posedge clk); #1; c++;
        end
        if (got_q.size() < n) begin
            total++; bad++;
            $display("FAIL drain_timeout: results=%0d required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        total++; if (out_valid2 !== 1'b0) begin bad++; $display("FAIL reset_out_valid2: got %b want 0", out_valid2); end
        @(posedge clk); #1;
    endtask

    task automatic test_select_sweep();
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'h10 + 8'(i);
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(2'd0, 3'(i), d);
        wait_got(8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== 8'h10 + 8'(i)) begin
                bad++; $display("FAIL sweep_data[%0d]: got %h want %h", i, got_q[i], 8'h10 + 8'(i));
            end
            total++;
            if (gcyc_q[i] - acc_q[i] != 3) begin
                bad++; $display("FAIL sweep_latency[%0d]: got %0d want 3", i, gcyc_q[i] - acc_q[i]);
            end
            total++;
            if (gcyc_q[i] != gcyc_q[0] + i) begin
                bad++; $display("FAIL sweep_continuous[%0d]: cycle %0d want %0d", i, gcyc_q[i], gcyc_q[0] + i);
            end
        end
    endtask

    task automatic test_reductions();
        logic [63:0] d1, d2, d3;
        logic [1:0]  ops [4];
        logic [7:0]  want [4];
        d1 = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3C, 8'hF0, 8'hFF};
        d2 = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        d3 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hAA};
        ops[0] = 2'd1; want[0] = 8'h30;
        ops[1] = 2'd2; want[1] = 8'hFF;
        ops[2] = 2'd3; want[2] = 8'hFF;
        ops[3] = 2'd3; want[3] = 8'h00;
        clear_q();
        send(ops[0], 3'd0, d1);
        send(ops[1], 3'd0, d2);
        send(ops[2], 3'd0, d2);
        send(ops[3], 3'd0, d3);
        wait_got(4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== want[i]) begin
                bad++; $display("FAIL reduce[%0d]: got %h want %h", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_mixed();
        logic [63:0] d;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            send(2'(i), (i == 0) ? 3'd5 : 3'($urandom_range(0, 7)), d);
        end
        wait_got(4);
        total++;
        if (got_q.size() != 4) begin bad++; $display("FAIL mixed_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL mixed[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] first;
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), {$urandom, $urandom});
        first = exp_q[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, out_valid); end
            total++; if (out_data !== first) begin bad++; $display("FAIL bp_stable[%0d]: got %h want %h", c, out_data, first); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_got(3);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (got_q.size() != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL bp_drain[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(2'd2, 3'd0, {$urandom, $urandom} | 64'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_q();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL midrst_out_data: got %h want 00", out_data); end
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (got_q.size() != 0) begin bad++; $display("FAIL midrst_stale: got %0d results want 0", got_q.size()); end
    endtask

    task automatic test_random_stall();
        bit done = 0;
        clear_q();
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), {$urandom, $urandom});
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_got(24);
        total++;
        if (got_q.size() != 24) begin bad++; $display("FAIL rand_count: got %0d want 24", got_q.size()); end
        for (int i = 0; i < 24 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rand[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_n2_exhaustive();
        logic w;
        out_ready2 = 1'b1;
        for (int op = 0; op < 4; op++) begin
            for (int v = 0; v < 8; v++) begin
                logic a, b, s;
                a = v[0]; b = v[1]; s = v[2];
                case (op)
                    0: w = s ? b : a;
                    1: w = a & b;
                    2: w = a | b;
                    default: w = a ^ b;
                endcase
                in_valid2 = 1'b1; in_op2 = 2'(op); in_sel2 = s; in_data2 = {b, a};
                @(negedge clk);
                total++;
                if (in_ready2 !== 1'b1) begin bad++; $display("FAIL n2_in_ready op=%0d v=%0d: got %b want 1", op, v, in_ready2); end
                @(posedge clk); #1;
                in_valid2 = 1'b0;
                @(negedge clk);
                total++;
                if (out_valid2 !== 1'b1 || out_data2 !== w) begin
                    bad++;
                    $display("FAIL n2_result op=%0d a=%0b b=%0b s=%0b: got v=%b d=%b want v=1 d=%b",
                             op, a, b, s, out_valid2, out_data2, w);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_select_sweep();
        test_reductions();
        test_mixed();
        test_backpressure();
        test_reset_midstream();
        test_random_stall();
        test_n2_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
